// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor
//   Sequences the PLL reset pin and the downstream system reset from the PLL lock output.
//   Everything runs in the free-running reference clock domain (clkin_i). The asynchronous lock
//   input goes through a two-flop synchroniser. sys_rst_o is released only after the
//   synchronised lock has stayed high for STABLE_CYCLES consecutive cycles. A lock loss in RUN
//   re-pulses the PLL reset.
//
// Ports
//   clkin_i         reference clock, all logic in this domain
//   reset_i         synchronous, active-high reset
//   lock_i          PLL lock, asynchronous to clkin_i
//   pll_reset_o     PLL reset pin, active-high
//   sys_rst_o       downstream system reset, active-high, synchronous to clkin_i
//   ready_o         high while the PLL is locked and the system is released
//   timeout_o       one-cycle pulse when lock is not seen within LOCK_TIMEOUT cycles
//   relock_count_o  saturating count of lock losses seen while running
//
// Configuration
//   PLL_SUP_RETRY_EN  defined: a lock timeout re-pulses the PLL reset (unlimited retries).
//                     undefined: one timeout pulse, then keep waiting for lock indefinitely.

module pll_lock_supervisor #(
  parameter int unsigned PLL_RST_CYCLES = 16,
  parameter int unsigned LOCK_TIMEOUT   = 27000,
  parameter int unsigned STABLE_CYCLES  = 1024,
  parameter int unsigned CNT_W          = 16,
  parameter int unsigned RELOCK_W       = 8
) (
  input  logic                clkin_i,
  input  logic                reset_i,
  input  logic                lock_i,
  output logic                pll_reset_o,
  output logic                sys_rst_o,
  output logic                ready_o,
  output logic                timeout_o,
  output logic [RELOCK_W-1:0] relock_count_o
);

  localparam logic [CNT_W-1:0] RstLast    = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] StableLast = CNT_W'(STABLE_CYCLES - 1);

  typedef enum logic [2:0] {
    StPllRst,
    StWait,
    StStable,
    StRun,
    StLost
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                lock_meta_q, lock_s_q;
  logic                timeout_d;
  logic [RELOCK_W-1:0] relock_q, relock_d;
  logic                pll_reset_q, sys_rst_q, ready_q, timeout_q;
`ifndef PLL_SUP_RETRY_EN
  // Remembers that this WAIT visit already reported its timeout.
  logic                to_done_q, to_done_d;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    relock_d  = relock_q;
`ifndef PLL_SUP_RETRY_EN
    to_done_d = to_done_q;
`endif
    case (state_q)
      StPllRst: begin
        if (cnt_q == RstLast) state_d = StWait;
        else                  cnt_d   = cnt_q + CNT_W'(1);
      end
      StWait: begin
        if (lock_s_q) begin
          state_d = StStable;
        end else if (cnt_q == TimeoutLast) begin
`ifdef PLL_SUP_RETRY_EN
          timeout_d = 1'b1;
          state_d   = StPllRst;
`else
          // Counter holds at its terminal value; pulse only once per WAIT visit.
          if (!to_done_q) begin
            timeout_d = 1'b1;
            to_done_d = 1'b1;
          end
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StStable: begin
        if (!lock_s_q)                state_d = StWait;
        else if (cnt_q == StableLast) state_d = StRun;
        else                          cnt_d   = cnt_q + CNT_W'(1);
      end
      StRun: begin
        if (!lock_s_q) begin
          state_d = StLost;
          if (relock_q != '1) relock_d = relock_q + RELOCK_W'(1);
        end
      end
      StLost:  state_d = StPllRst;
      default: state_d = StPllRst;
    endcase

    if (state_d != state_q) begin
      cnt_d = '0;
`ifndef PLL_SUP_RETRY_EN
      to_done_d = 1'b0;
`endif
    end
  end

  // Outputs are decoded from the next state so they move on the same edge as the state.
  always_ff @(posedge clkin_i) begin
    if (reset_i) begin
      state_q     <= StPllRst;
      cnt_q       <= '0;
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
      relock_q    <= '0;
      pll_reset_q <= 1'b1;
      sys_rst_q   <= 1'b1;
      ready_q     <= 1'b0;
      timeout_q   <= 1'b0;
`ifndef PLL_SUP_RETRY_EN
      to_done_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lock_meta_q <= lock_i;
      lock_s_q    <= lock_meta_q;
      relock_q    <= relock_d;
      pll_reset_q <= (state_d == StPllRst);
      sys_rst_q   <= (state_d != StRun);
      ready_q     <= (state_d == StRun);
      timeout_q   <= timeout_d;
`ifndef PLL_SUP_RETRY_EN
      to_done_q   <= to_done_d;
`endif
    end
  end

  assign pll_reset_o    = pll_reset_q;
  assign sys_rst_o      = sys_rst_q;
  assign ready_o        = ready_q;
  assign timeout_o      = timeout_q;
  assign relock_count_o = relock_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Testbench for pll_lock_supervisor: table-driven vectors, hand-written multi-cycle sequences
// and a randomized lock pattern, all compared every cycle against a phase/elapsed-time model.

module tb_pll_lock_supervisor;

  localparam int P  = 4;
  localparam int T  = 20;
  localparam int S  = 8;
  localparam int RW = 2;
  localparam int RC_MAX = (1 << RW) - 1;

  logic          clkin_i = 1'b0;
  logic          reset_i = 1'b1;
  logic          lock_i  = 1'b0;
  logic          pll_reset_o, sys_rst_o, ready_o, timeout_o;
  logic [RW-1:0] relock_count_o;

  pll_lock_supervisor #(
    .PLL_RST_CYCLES(P),
    .LOCK_TIMEOUT  (T),
    .STABLE_CYCLES (S),
    .CNT_W         (16),
    .RELOCK_W      (RW)
  ) dut (
    .clkin_i       (clkin_i),
    .reset_i       (reset_i),
    .lock_i        (lock_i),
    .pll_reset_o   (pll_reset_o),
    .sys_rst_o     (sys_rst_o),
    .ready_o       (ready_o),
    .timeout_o     (timeout_o),
    .relock_count_o(relock_count_o)
  );

  always #5 clkin_i = ~clkin_i;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: phase name + cycles spent in it ----------------
  localparam int PhRst = 0, PhWait = 1, PhStable = 2, PhRun = 3, PhLost = 4;
  int   m_ph    = PhRst;
  int   m_age   = 1;     // cycles the current phase has been visible, including this one
  logic m_l1    = 1'b0;  // lock delayed by one edge
  logic m_l2    = 1'b0;  // lock delayed by two edges (what the sequencer acts on)
  logic m_to    = 1'b0;
  logic m_fired = 1'b0;
  int   m_rc    = 0;

  task automatic enter(input int ph);
    m_ph = ph; m_age = 1; m_fired = 1'b0;
  endtask

  task automatic model_step(input logic r, input logic l);
    logic seen;
    seen = m_l2;
    if (r) begin
      enter(PhRst); m_rc = 0; m_to = 1'b0; m_l1 = 1'b0; m_l2 = 1'b0;
      return;
    end
    m_l2 = m_l1; m_l1 = l; m_to = 1'b0;
    case (m_ph)
      PhRst:    if (m_age >= P) enter(PhWait); else m_age++;
      PhWait: begin
        if (seen) enter(PhStable);
        else if (m_age >= T) begin
`ifdef PLL_SUP_RETRY_EN
          m_to = 1'b1; enter(PhRst);
`else
          if (!m_fired) begin m_to = 1'b1; m_fired = 1'b1; end
`endif
        end else m_age++;
      end
      PhStable: if (!seen) enter(PhWait); else if (m_age >= S) enter(PhRun); else m_age++;
      PhRun:    if (!seen) begin enter(PhLost); m_rc = (m_rc < RC_MAX) ? m_rc + 1 : RC_MAX; end
      default:  enter(PhRst);
    endcase
  endtask

  task automatic tick(input logic r, input logic l);
    reset_i = r;
    lock_i  = l;
    @(posedge clkin_i);
    model_step(r, l);
    #1;
    chk("pll_reset",    int'(pll_reset_o),    int'(m_ph == PhRst));
    chk("sys_rst",      int'(sys_rst_o),      int'(m_ph != PhRun));
    chk("ready",        int'(ready_o),        int'(m_ph == PhRun));
    chk("timeout",      int'(timeout_o),      int'(m_to));
    chk("relock_count", int'(relock_count_o), m_rc);
  endtask

  // Holds lock high and counts edges until sys_rst falls (bounded).
  task automatic count_release(output int n);
    n = 0;
    do begin
      tick(1'b0, 1'b1);
      n++;
    end while (sys_rst_o && n < 40);
  endtask

  typedef struct {
    logic r, l;
    int   n;
    logic pr, sr, rdy, to;
    int   rc;
  } vec_t;

  vec_t tbl[15];

  initial begin
    int   n, n_to;
    logic prt;
    int   exp_rc[5];
`ifdef PLL_SUP_RETRY_EN
    prt = 1'b1;
`else
    prt = 1'b0;
`endif
    //              r     l     n   pr    sr    rdy   to    rc
    tbl[0]  = '{1'b1, 1'b0,  1, 1'b1, 1'b1, 1'b0, 1'b0, 0};  // reset values
    tbl[1]  = '{1'b0, 1'b0,  3, 1'b1, 1'b1, 1'b0, 1'b0, 0};  // PLL reset cycles 2..4
    tbl[2]  = '{1'b0, 1'b0,  1, 1'b0, 1'b1, 1'b0, 1'b0, 0};  // WAIT cycle 1
    tbl[3]  = '{1'b0, 1'b0, 19, 1'b0, 1'b1, 1'b0, 1'b0, 0};  // WAIT cycle 20
    tbl[4]  = '{1'b0, 1'b0,  1, prt,  1'b1, 1'b0, 1'b1, 0};  // timeout pulse
    tbl[5]  = '{1'b0, 1'b0,  1, prt,  1'b1, 1'b0, 1'b0, 0};  // pulse gone
    tbl[6]  = '{1'b1, 1'b1,  1, 1'b1, 1'b1, 1'b0, 1'b0, 0};  // reset with lock high
    tbl[7]  = '{1'b0, 1'b1, 12, 1'b0, 1'b1, 1'b0, 1'b0, 0};  // last STABLE cycle
    tbl[8]  = '{1'b0, 1'b1,  1, 1'b0, 1'b0, 1'b1, 1'b0, 0};  // released
    tbl[9]  = '{1'b0, 1'b0,  2, 1'b0, 1'b0, 1'b1, 1'b0, 0};  // loss still in synchroniser
    tbl[10] = '{1'b0, 1'b0,  1, 1'b0, 1'b1, 1'b0, 1'b0, 1};  // LOST, 3 cycles after loss
    tbl[11] = '{1'b0, 1'b0,  1, 1'b1, 1'b1, 1'b0, 1'b0, 1};  // PLL reset again
    tbl[12] = '{1'b0, 1'b0,  3, 1'b1, 1'b1, 1'b0, 1'b0, 1};
    tbl[13] = '{1'b0, 1'b0,  1, 1'b0, 1'b1, 1'b0, 1'b0, 1};  // WAIT
    tbl[14] = '{1'b0, 1'b1,  1, 1'b0, 1'b1, 1'b0, 1'b0, 1};

    for (int i = 0; i < 15; i++) begin
      repeat (tbl[i].n) tick(tbl[i].r, tbl[i].l);
      chk($sformatf("vec%0d.pll_reset", i), int'(pll_reset_o), int'(tbl[i].pr));
      chk($sformatf("vec%0d.sys_rst", i),   int'(sys_rst_o),   int'(tbl[i].sr));
      chk($sformatf("vec%0d.ready", i),     int'(ready_o),     int'(tbl[i].rdy));
      chk($sformatf("vec%0d.timeout", i),   int'(timeout_o),   int'(tbl[i].to));
      chk($sformatf("vec%0d.relock", i),    int'(relock_count_o), tbl[i].rc);
    end

    // Lock stays low: count timeout pulses, then lock releases 11 edges after first sample.
    tick(1'b1, 1'b0);
    n_to = 0;
    repeat (60) begin
      tick(1'b0, 1'b0);
      if (timeout_o) n_to++;
    end
`ifdef PLL_SUP_RETRY_EN
    chk("timeout_pulses", n_to, 2);
`else
    chk("timeout_pulses", n_to, 1);
    chk("pll_reset_after_timeout", int'(pll_reset_o), 0);
`endif
    count_release(n);
    chk("release_after_wait", n, 11);

    // Lock dropout mid-STABLE returns to WAIT; release 11 edges after lock returns.
    tick(1'b1, 1'b1);
    repeat (8) tick(1'b0, 1'b1);
    repeat (3) tick(1'b0, 1'b0);
    chk("dropout_sys_rst", int'(sys_rst_o), 1);
    count_release(n);
    chk("release_after_dropout", n, 11);

    // Five lock losses from RUN: relock_count saturates.
    exp_rc = '{1, 2, 3, 3, 3};
    for (int k = 0; k < 5; k++) begin
      repeat (5) tick(1'b0, 1'b0);
      chk($sformatf("relock_%0d", k), int'(relock_count_o), exp_rc[k]);
      repeat (25) tick(1'b0, 1'b1);
      chk($sformatf("rerun_%0d", k), int'(ready_o), 1);
    end

    // Reset in the middle of STABLE: everything back to reset values on that edge.
    repeat (5) tick(1'b0, 1'b0);
    n = 0;
    while (!(m_ph == PhStable && m_age == 4) && n < 40) begin
      tick(1'b0, 1'b1);
      n++;
    end
    chk("reach_stable", int'(n < 40), 1);
    tick(1'b1, 1'b1);
    chk("midrst.pll_reset", int'(pll_reset_o), 1);
    chk("midrst.sys_rst",   int'(sys_rst_o),   1);
    chk("midrst.ready",     int'(ready_o),     0);
    chk("midrst.timeout",   int'(timeout_o),   0);
    chk("midrst.relock",    int'(relock_count_o), 0);

    // Randomized lock pattern with occasional resets; the model checks every cycle.
    for (int seg = 0; seg < 70; seg++) begin
      logic lvl;
      int   len;
      if ($urandom_range(0, 19) == 0) begin
        tick(1'b1, 1'($urandom_range(0, 1)));
      end else begin
        lvl = ($urandom_range(0, 3) != 0);
        len = lvl ? $urandom_range(1, 40) : $urandom_range(1, 30);
        repeat (len) tick(1'b0, lvl);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
